// File: rtl/ex_stage_if.sv
// Bus bundle between decode/controller and the execute stage.
interface ex_stage_if;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         pre_inst_is_load;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;
    logic [64:0]  ex_to_hilo_bus;

    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_rf_bus, pre_inst_is_load,
        input  data_sram_en, data_sram_wen, data_sram_addr,
        input  data_sram_wdata, stallreq_for_ex, ex_to_hilo_bus
    );

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_rf_bus, pre_inst_is_load,
        output data_sram_en, data_sram_wen, data_sram_addr,
        output data_sram_wdata, stallreq_for_ex, ex_to_hilo_bus
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, data-SRAM request, bypass and result forwarding.
// Define EX_DIV_EN to build the iterative 32-cycle DIV/DIVU unit.
module ex_stage (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);
    logic [158:0] r_id_to_ex;

    always_ff @(posedge clk) begin
        if (rst)
            r_id_to_ex <= '0;
        else if (bus.stall[2] && !bus.stall[3])
            r_id_to_ex <= '0;
        else if (!bus.stall[2])
            r_id_to_ex <= bus.id_to_ex_bus;
    end

    logic [31:0] w_pc, w_inst, w_data1, w_data2;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel_src1;
    logic [3:0]  w_sel_src2;
    logic        w_ram_en, w_rf_we, w_sel_rf_res;
    logic [3:0]  w_ram_wen;
    logic [4:0]  w_rf_waddr;

    assign {w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2,
            w_ram_en, w_ram_wen, w_rf_we, w_rf_waddr,
            w_sel_rf_res, w_data1, w_data2} = r_id_to_ex;

    logic w_unused_inst;
    assign w_unused_inst = ^w_inst[25:16];

    logic w_is_div, w_div_signed;
    assign w_is_div = (w_inst[31:26] == 6'd0) &&
                      (w_inst[5:1] == 5'b01101);
    assign w_div_signed = !w_inst[0];

    logic [31:0] w_src1, w_src2, w_alu_res, w_ex_result;

    always_comb begin
        w_src1 = '0;
        unique case (1'b1)
            w_sel_src1[0]: w_src1 = w_data1;
            w_sel_src1[1]: w_src1 = w_pc;
            w_sel_src1[2]: w_src1 = {27'b0, w_inst[10:6]};
            default:       w_src1 = '0;
        endcase
    end

    always_comb begin
        w_src2 = '0;
        unique case (1'b1)
            w_sel_src2[0]: w_src2 = w_data2;
            w_sel_src2[1]: w_src2 = {{16{w_inst[15]}}, w_inst[15:0]};
            w_sel_src2[2]: w_src2 = 32'd8;
            w_sel_src2[3]: w_src2 = {16'b0, w_inst[15:0]};
            default:       w_src2 = '0;
        endcase
    end

    always_comb begin
        w_alu_res = '0;
        unique case (1'b1)
            w_alu_op[11]: w_alu_res = w_src1 + w_src2;
            w_alu_op[10]: w_alu_res = w_src1 - w_src2;
            w_alu_op[9]:  w_alu_res = {31'b0, $signed(w_src1) < $signed(w_src2)};
            w_alu_op[8]:  w_alu_res = {31'b0, w_src1 < w_src2};
            w_alu_op[7]:  w_alu_res = w_src1 & w_src2;
            w_alu_op[6]:  w_alu_res = ~(w_src1 | w_src2);
            w_alu_op[5]:  w_alu_res = w_src1 | w_src2;
            w_alu_op[4]:  w_alu_res = w_src1 ^ w_src2;
            w_alu_op[3]:  w_alu_res = w_src2 << w_src1[4:0];
            w_alu_op[2]:  w_alu_res = w_src2 >> w_src1[4:0];
            w_alu_op[1]:  w_alu_res = $signed(w_src2) >>> w_src1[4:0];
            w_alu_op[0]:  w_alu_res = {w_src2[15:0], 16'b0};
            default:      w_alu_res = '0;
        endcase
    end

    assign w_ex_result = w_is_div ? 32'd0 : w_alu_res;

    logic [3:0]  w_sram_wen;
    logic [31:0] w_sram_wdata;

    // Byte lanes follow the low address bits; the bus to MEM keeps the raw code.
    always_comb begin
        w_sram_wen   = 4'b0000;
        w_sram_wdata = w_data2;
        unique case (w_ram_wen)
            4'b0001: begin
                w_sram_wen   = 4'b0001 << w_ex_result[1:0];
                w_sram_wdata = {4{w_data2[7:0]}};
            end
            4'b0011: begin
                w_sram_wen   = w_ex_result[1] ? 4'b1100 : 4'b0011;
                w_sram_wdata = {2{w_data2[15:0]}};
            end
            4'b1111: begin
                w_sram_wen   = 4'b1111;
                w_sram_wdata = w_data2;
            end
            default: begin
                w_sram_wen   = 4'b0000;
                w_sram_wdata = w_data2;
            end
        endcase
    end

    assign bus.data_sram_en     = w_ram_en;
    assign bus.data_sram_wen    = w_sram_wen;
    assign bus.data_sram_addr   = w_ex_result;
    assign bus.data_sram_wdata  = w_sram_wdata;
    assign bus.pre_inst_is_load = w_sel_rf_res;
    assign bus.ex_to_rf_bus     = {w_rf_we, w_rf_waddr, w_ex_result};
    assign bus.ex_to_mem_bus    = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res,
                                   w_rf_we, w_rf_waddr, w_ex_result};

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    div_state_t  r_state, w_next_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_quot, r_rem, r_dvsr;
    logic        w_stallreq, w_hilo_we;

    logic [31:0] w_abs1, w_abs2;
    assign w_abs1 = (w_div_signed && w_data1[31]) ? -w_data1 : w_data1;
    assign w_abs2 = (w_div_signed && w_data2[31]) ? -w_data2 : w_data2;

    logic [32:0] w_trial, w_diff;
    logic        w_ge;
    assign w_trial = {r_rem, r_quot[31]};
    assign w_diff  = w_trial - {1'b0, r_dvsr};
    assign w_ge    = w_trial >= {1'b0, r_dvsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dvsr  <= '0;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                S_IDLE: begin
                    if (w_is_div) begin
                        r_quot <= w_abs1;
                        r_rem  <= '0;
                        r_dvsr <= w_abs2;
                        r_cnt  <= '0;
                    end
                end
                S_BUSY: begin
                    r_quot <= {r_quot[30:0], w_ge};
                    r_rem  <= w_ge ? w_diff[31:0] : w_trial[31:0];
                    r_cnt  <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_stallreq   = 1'b0;
        w_hilo_we    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_is_div) begin
                    w_stallreq   = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stallreq = 1'b1;
                if (r_cnt == 5'd31)
                    w_next_state = S_DONE;
            end
            S_DONE: begin
                w_hilo_we    = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operands are still held in the input register while the divide runs.
    logic        w_neg_q, w_neg_r, w_dvsr_zero;
    logic [31:0] w_lo, w_hi;
    assign w_neg_q     = w_div_signed && (w_data1[31] ^ w_data2[31]);
    assign w_neg_r     = w_div_signed && w_data1[31];
    assign w_dvsr_zero = (w_data2 == 32'd0);
    assign w_lo = w_dvsr_zero ? 32'hFFFF_FFFF : (w_neg_q ? -r_quot : r_quot);
    assign w_hi = w_dvsr_zero ? w_data1 : (w_neg_r ? -r_rem : r_rem);

    assign bus.stallreq_for_ex = w_stallreq;
    assign bus.ex_to_hilo_bus  = w_hilo_we ? {1'b1, w_hi, w_lo} : 65'd0;
`else
    logic w_unused_div;
    assign w_unused_div = w_div_signed;

    assign bus.stallreq_for_ex = 1'b0;
    assign bus.ex_to_hilo_bus  = 65'd0;
`endif
endmodule
